// File: rtl/minmax_tracker.sv
// Windowed running min/max tracker with valid/ready in and out.
// Each window of WINDOW samples yields min, max and their first-occurrence indices.
module minmax_tracker #(
    parameter int N_WIDTH = 4,
    parameter bit SIGNED  = 1'b1,
    parameter int WINDOW  = 8,
    localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [N_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] out_min,
    output logic [N_WIDTH-1:0] out_max,
    output logic [CNT_W-1:0]   out_min_idx,
    output logic [CNT_W-1:0]   out_max_idx
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_WIDTH-1:0] min_q, max_q;
    logic [CNT_W-1:0]   min_idx_q, max_idx_q;
    logic               out_valid_q;

    logic accept, lt_min, gt_max, last;

    assign in_ready = (state_q != DONE) && !clear;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == CNT_W'(WINDOW - 1));

    generate
        if (SIGNED) begin : g_signed
            assign lt_min = $signed(in_data) < $signed(min_q);
            assign gt_max = $signed(in_data) > $signed(max_q);
        end else begin : g_unsigned
            assign lt_min = in_data < min_q;
            assign gt_max = in_data > max_q;
        end
    endgenerate

    // Count saturates at WINDOW-1 on the final sample instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            min_idx_q   <= '0;
            max_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        min_q     <= in_data;
                        max_q     <= in_data;
                        min_idx_q <= '0;
                        max_idx_q <= '0;
                        if (WINDOW == 1) begin
                            state_q     <= DONE;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (lt_min) begin
                            min_q     <= in_data;
                            min_idx_q <= cnt_q;
                        end
                        if (gt_max) begin
                            max_q     <= in_data;
                            max_idx_q <= cnt_q;
                        end
                        if (last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: signed/unsigned W=8 and signed W=1 instances
// share one input stream; each test resets and checks the relevant instance.
module tb_minmax_tracker;

    logic       clk, rst, clear, in_valid, out_ready;
    logic [3:0] in_data;

    logic       s_in_ready, s_out_valid;
    logic [3:0] s_min, s_max;
    logic [2:0] s_min_idx, s_max_idx;
    logic       u_in_ready, u_out_valid;
    logic [3:0] u_min, u_max;
    logic [2:0] u_min_idx, u_max_idx;
    logic       w_in_ready, w_out_valid;
    logic [3:0] w_min, w_max;
    logic [0:0] w_min_idx, w_max_idx;

    int total = 0;
    int bad   = 0;

    minmax_tracker #(.N_WIDTH(4), .SIGNED(1'b1), .WINDOW(8)) u_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_min(s_min), .out_max(s_max), .out_min_idx(s_min_idx), .out_max_idx(s_max_idx));

    minmax_tracker #(.N_WIDTH(4), .SIGNED(1'b0), .WINDOW(8)) u_u (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(u_in_ready), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_min(u_min), .out_max(u_max), .out_min_idx(u_min_idx), .out_max_idx(u_max_idx));

    minmax_tracker #(.N_WIDTH(4), .SIGNED(1'b1), .WINDOW(1)) u_w1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_min(w_min), .out_max(w_max), .out_min_idx(w_min_idx), .out_max_idx(w_max_idx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    logic [3:0] v1 [8];
    logic [3:0] v2 [8];

    initial begin
        v1 = '{4'h3, 4'h8, 4'h7, 4'h0, 4'h8, 4'h7, 4'h1, 4'hF};
        v2 = '{4'h3, 4'h8, 4'h7, 4'h0, 4'h8, 4'h7, 4'h1, 4'hF};
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        do_reset();
        chk("rst_valid", s_out_valid, 1'b0);
        chk("rst_min",   s_min, 4'h0);
        chk("rst_max",   s_max, 4'h0);
        chk("rst_idx",   {s_min_idx, s_max_idx}, 6'd0);
        chk("rst_ready", s_in_ready, 1'b1);

        // Test 1: signed window
        for (int i = 0; i < 8; i++) begin
            send(v1[i]);
            if (i == 6) chk("t1_not_yet", s_out_valid, 1'b0);
        end
        in_valid = 1'b0;
        chk("t1_valid",   s_out_valid, 1'b1);
        chk("t1_min",     s_min, 4'h8);
        chk("t1_min_idx", s_min_idx, 3'd1);
        chk("t1_max",     s_max, 4'h7);
        chk("t1_max_idx", s_max_idx, 3'd2);
        chk("t1_ready",   s_in_ready, 1'b0);
        tick();
        chk("t1_hs_valid", s_out_valid, 1'b0);
        chk("t1_hs_ready", s_in_ready, 1'b1);

        // Test 2: unsigned window
        do_reset();
        for (int i = 0; i < 8; i++) send(v2[i]);
        in_valid = 1'b0;
        chk("t2_valid",   u_out_valid, 1'b1);
        chk("t2_min",     u_min, 4'h0);
        chk("t2_min_idx", u_min_idx, 3'd3);
        chk("t2_max",     u_max, 4'hF);
        chk("t2_max_idx", u_max_idx, 3'd7);

        // Test 3: output backpressure on the signed instance
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'(i));
        in_data = 4'h9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", s_out_valid, 1'b1);
            chk("t3_hold_ready", s_in_ready, 1'b0);
            chk("t3_hold_min",   {s_min, s_min_idx}, {4'h0, 3'd0});
            chk("t3_hold_max",   {s_max, s_max_idx}, {4'h7, 3'd7});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_rel_valid", s_out_valid, 1'b0);
        chk("t3_rel_ready", s_in_ready, 1'b1);
        send(4'h5);
        in_valid = 1'b0;
        chk("t3_new_min", {s_min, s_min_idx}, {4'h5, 3'd0});
        chk("t3_new_max", {s_max, s_max_idx}, {4'h5, 3'd0});

        // Test 4: clear mid-window on the unsigned instance
        do_reset();
        for (int i = 0; i < 4; i++) send(4'(9 + i));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h0;
        #1;
        chk("t4_clear_ready", u_in_ready, 1'b0);
        tick();
        clear = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(4'(i));
            if (i == 7) chk("t4_not_yet", u_out_valid, 1'b0);
        end
        in_valid = 1'b0;
        chk("t4_valid", u_out_valid, 1'b1);
        chk("t4_min",   {u_min, u_min_idx}, {4'h1, 3'd0});
        chk("t4_max",   {u_max, u_max_idx}, {4'h8, 3'd7});

        // Test 5: async reset between edges, in ACCUM then in DONE
        do_reset();
        send(4'h3); send(4'h8); send(4'h7);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5a_min", {s_min, s_min_idx}, 7'd0);
        chk("t5a_max", {s_max, s_max_idx}, 7'd0);
        rst = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(v1[i]);
        in_valid = 1'b0;
        chk("t5b_done", s_out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5b_valid", s_out_valid, 1'b0);
        chk("t5b_out",   {s_min, s_max, s_min_idx, s_max_idx}, 14'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send(4'h6);
        in_valid = 1'b0;
        chk("t5_resume", {s_min, s_max}, 8'h66);

        // Test 6: WINDOW=1 instance
        do_reset();
        send(4'h5);
        chk("t6_valid0", w_out_valid, 1'b1);
        chk("t6_out0",   {w_min, w_max, w_min_idx, w_max_idx}, {4'h5, 4'h5, 2'b00});
        chk("t6_ready0", w_in_ready, 1'b0);
        in_data = 4'hD;
        tick();
        chk("t6_gap_valid", w_out_valid, 1'b0);
        chk("t6_gap_ready", w_in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6_valid1", w_out_valid, 1'b1);
        chk("t6_out1",   {w_min, w_max, w_min_idx, w_max_idx}, {4'hD, 4'hD, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
